// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants and types for the LCD serial bus receiver
package lcd_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  // FIFO entry layout: {data[7:0], dc, first}
  localparam int ENTRY_W = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/lcd_rx_fifo.sv
// rtl/lcd_rx_fifo.sv - synchronous show-ahead FIFO with extra-bit pointers
module lcd_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_full,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);

  // Full is judged on the current pointers, so a same-cycle pop never frees room for a write
  assign w_push = i_wr_en && !o_full;
  assign w_pop  = i_rd_en && !o_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/lcd_spi_rx.sv
// rtl/lcd_spi_rx.sv - passive ST7789 4-wire serial bus monitor with output FIFO
// Optional RGB565 pixel pairing after RAMWR is built when LCD_RX_PIXEL_EN is defined.
module lcd_spi_rx
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_scl,
  input  logic        spi_cs,
  input  logic        spi_sd,
  input  logic        spi_rs,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_dc,
  output logic        out_first,
  output logic        overflow,
  output logic        frame_err,
  input  logic        clear,
  output logic        pix_valid,
  output logic [15:0] pix_data
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sd_sync;
  logic [SYNC_STAGES-1:0] r_rs_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync <= '0;
      r_cs_sync  <= '1;
      r_sd_sync  <= '0;
      r_rs_sync  <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], spi_scl};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0],  spi_cs};
      r_sd_sync  <= {r_sd_sync[SYNC_STAGES-2:0],  spi_sd};
      r_rs_sync  <= {r_rs_sync[SYNC_STAGES-2:0],  spi_rs};
    end
  end

  // Registered edge detect; cs/sd/rs are delayed by the same stage so they stay aligned with scl_rise
  logic r_scl_prev;
  logic r_scl_rise;
  logic r_cs_d;
  logic r_sd_d;
  logic r_rs_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_prev <= 1'b0;
      r_scl_rise <= 1'b0;
      r_cs_d     <= 1'b1;
      r_sd_d     <= 1'b0;
      r_rs_d     <= 1'b0;
    end else begin
      r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
      r_scl_rise <= r_scl_sync[SYNC_STAGES-1] & ~r_scl_prev;
      r_cs_d     <= r_cs_sync[SYNC_STAGES-1];
      r_sd_d     <= r_sd_sync[SYNC_STAGES-1];
      r_rs_d     <= r_rs_sync[SYNC_STAGES-1];
    end
  end

  rx_state_t r_state;
  rx_state_t w_state_nxt;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nxt;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_nxt;
  logic       r_first;
  logic       w_first_nxt;
  logic       w_wr_en;
  logic       w_frame_set;
  logic [7:0] w_byte;

  assign w_byte = {r_shift[6:0], r_sd_d};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_first   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_first   <= w_first_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_first_nxt   = r_first;
    w_wr_en       = 1'b0;
    w_frame_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_cs_d) begin
          w_state_nxt   = ST_SHIFT;
          w_bit_cnt_nxt = '0;
          w_first_nxt   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (r_cs_d) begin
          w_state_nxt   = ST_IDLE;
          w_frame_set   = (r_bit_cnt != 3'd0);
          w_bit_cnt_nxt = '0;
        end else if (r_scl_rise) begin
          w_shift_nxt = w_byte;
          if (r_bit_cnt == 3'd7) begin
            w_wr_en       = 1'b1;
            w_bit_cnt_nxt = '0;
            w_first_nxt   = 1'b0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
    endcase
  end

  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_head;

  lcd_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_data ({w_byte, r_rs_d, r_first}),
    .o_full    (w_full),
    .i_rd_en   (out_valid & out_ready),
    .o_rd_data (w_head),
    .o_empty   (w_empty)
  );

  // Head is masked while empty so the unreset storage never shows on the outputs
  assign out_valid = ~w_empty;
  assign out_data  = out_valid ? w_head[9:2] : 8'h00;
  assign out_dc    = out_valid & w_head[1];
  assign out_first = out_valid & w_head[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= (w_wr_en & w_full) | (overflow & ~clear);
      frame_err <= w_frame_set | (frame_err & ~clear);
    end
  end

`ifdef LCD_RX_PIXEL_EN
  logic       r_pix_armed;
  logic       r_pix_have_hi;
  logic [7:0] r_pix_hi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix_armed   <= 1'b0;
      r_pix_have_hi <= 1'b0;
      r_pix_hi      <= '0;
    end else if (r_cs_d) begin
      r_pix_armed   <= 1'b0;
      r_pix_have_hi <= 1'b0;
    end else if (w_wr_en) begin
      if (!r_rs_d) begin
        r_pix_armed   <= (w_byte == CMD_RAMWR);
        r_pix_have_hi <= 1'b0;
      end else if (r_pix_armed) begin
        r_pix_have_hi <= ~r_pix_have_hi;
        if (!r_pix_have_hi) r_pix_hi <= w_byte;
      end
    end
  end

  assign pix_valid = w_wr_en & r_rs_d & r_pix_armed & r_pix_have_hi;
  assign pix_data  = pix_valid ? {r_pix_hi, w_byte} : 16'h0000;
`else
  assign pix_valid = 1'b0;
  assign pix_data  = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb/tb_lcd_spi_rx.sv - randomized self-checking bench for lcd_spi_rx against a queue model
module tb_lcd_spi_rx;

  localparam int FD = 8;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_scl, spi_cs, spi_sd, spi_rs;
  logic        out_valid, out_ready, out_dc, out_first;
  logic [7:0]  out_data;
  logic        overflow, frame_err, clear;
  logic        pix_valid;
  logic [15:0] pix_data;

  lcd_spi_rx #(.FIFO_DEPTH(FD), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .spi_scl(spi_scl), .spi_cs(spi_cs), .spi_sd(spi_sd),
    .spi_rs(spi_rs), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dc(out_dc), .out_first(out_first), .overflow(overflow), .frame_err(frame_err),
    .clear(clear), .pix_valid(pix_valid), .pix_data(pix_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] exp_q[$];
  logic       exp_ovf;
  logic       exp_ferr;
  logic [7:0] fr_b[$];
  logic       fr_rs[$];

  int          pix_cnt = 0;
  logic [15:0] pix_last = 16'h0;

  always @(negedge clk) begin
    if (pix_valid) begin
      pix_cnt  = pix_cnt + 1;
      pix_last = pix_data;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_push(input logic [7:0] b, input logic rs, input logic first);
    if (exp_q.size() < FD) exp_q.push_back({b, rs, first});
    else exp_ovf = 1'b1;
  endtask

  task automatic send_bit(input logic b, input logic rs);
    spi_scl = 1'b0; spi_sd = b; spi_rs = rs;
    wait_clk(4);
    spi_scl = 1'b1;
    wait_clk(4);
  endtask

  task automatic cs_fall;
    spi_cs = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_rise;
    spi_scl = 1'b0;
    wait_clk(4);
    spi_cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rs, input logic first);
    for (int i = 7; i >= 0; i--) send_bit(b[i], rs);
    model_push(b, rs, first);
  endtask

  task automatic send_frame;
    cs_fall();
    for (int i = 0; i < fr_b.size(); i++) send_byte(fr_b[i], fr_rs[i], i == 0);
    cs_rise();
    fr_b.delete();
    fr_rs.delete();
  endtask

  task automatic add(input logic [7:0] b, input logic rs);
    fr_b.push_back(b);
    fr_rs.push_back(rs);
  endtask

  task automatic do_reset;
    spi_scl = 1'b0; spi_cs = 1'b1; spi_sd = 1'b0; spi_rs = 1'b0;
    out_ready = 1'b0; clear = 1'b0;
    rst = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(3);
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_ferr = 1'b0;
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    wait_clk(1);
    clear = 1'b0;
    wait_clk(1);
    exp_ovf = 1'b0;
    exp_ferr = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic [9:0] e;
    logic [9:0] got;
    int t;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = 0;
      while (!out_valid && t < 60) begin
        wait_clk(1);
        t++;
      end
      n_vec++;
      if (!out_valid) begin
        n_err++;
        $display("FAIL %s_timeout: out_valid=0, required entry %h", tag, e);
      end else begin
        got = {out_data, out_dc, out_first};
        if (got !== e) begin
          n_err++;
          $display("FAIL %s_entry: got data=%h dc=%b first=%b, required data=%h dc=%b first=%b",
                   tag, got[9:2], got[1], got[0], e[9:2], e[1], e[0]);
        end
        out_ready = 1'b1;
        wait_clk(1);
        out_ready = 1'b0;
      end
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_empty: out_valid=%b, required 0", tag, out_valid);
    end
  endtask

  task automatic check_flags(input string tag);
    n_vec++;
    if ({overflow, frame_err} !== {exp_ovf, exp_ferr}) begin
      n_err++;
      $display("FAIL %s_flags: got ovf=%b ferr=%b, required ovf=%b ferr=%b",
               tag, overflow, frame_err, exp_ovf, exp_ferr);
    end
  endtask

  task automatic test_reset;
    spi_scl = 1'b0; spi_cs = 1'b1; spi_sd = 1'b1; spi_rs = 1'b1;
    out_ready = 1'b0; clear = 1'b0;
    rst = 1'b0;
    wait_clk(3);
    n_vec++;
    if ({out_valid, out_data, out_dc, out_first, overflow, frame_err, pix_valid, pix_data} !== 30'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b data=%h flags=%b%b pix=%b/%h, required all 0",
               out_valid, out_data, overflow, frame_err, pix_valid, pix_data);
    end
    do_reset();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_caset;
    add(8'h2A, 1'b0); add(8'h00, 1'b1); add(8'hEF, 1'b1);
    send_frame();
    check_flags("caset");
    drain("caset");
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 10; i++) add(i[7:0], 1'b1);
    send_frame();
    check_flags("ovf_set");
    drain("ovf");
    pulse_clear();
    check_flags("ovf_clear");
  endtask

  task automatic test_frame_err;
    logic [7:0] b;
    b = 8'hA5;
    cs_fall();
    for (int i = 7; i >= 3; i--) send_bit(b[i], 1'b1);
    cs_rise();
    exp_ferr = 1'b1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ferr_no_entry: out_valid=%b, required 0", out_valid);
    end
    check_flags("ferr_set");
    pulse_clear();
    check_flags("ferr_clear");
    add(8'h3C, 1'b1);
    send_frame();
    drain("ferr_next");
  endtask

  task automatic test_latency;
    logic [7:0] b;
    int lat;
    b = 8'h80;
    lat = -1;
    cs_fall();
    for (int i = 7; i >= 1; i--) send_bit(b[i], 1'b1);
    spi_scl = 1'b0; spi_sd = b[0];
    wait_clk(4);
    spi_scl = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    n_vec++;
    if (lat != SS + 2) begin
      n_err++;
      $display("FAIL latency: got %0d clks, required %0d", lat, SS + 2);
    end
    wait_clk(4);
    model_push(b, 1'b1, 1'b1);
    cs_rise();
    drain("latency");
  endtask

  task automatic test_pixel;
    int p0;
    p0 = pix_cnt;
    add(8'h2C, 1'b0); add(8'hF8, 1'b1); add(8'h00, 1'b1); add(8'h07, 1'b1); add(8'h29, 1'b0);
    send_frame();
    drain("pixel");
`ifdef LCD_RX_PIXEL_EN
    n_vec++;
    if (pix_cnt - p0 != 1 || pix_last !== 16'hF800) begin
      n_err++;
      $display("FAIL pixel_pair: got %0d pulses last=%h, required 1 pulse F800", pix_cnt - p0, pix_last);
    end
`else
    n_vec++;
    if (pix_cnt - p0 != 0) begin
      n_err++;
      $display("FAIL pixel_disabled: got %0d pulses, required 0", pix_cnt - p0);
    end
`endif
  endtask

  task automatic test_reset_mid;
    cs_fall();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
    #2 rst = 1'b0;
    wait_clk(2);
    spi_cs = 1'b1; spi_scl = 1'b0;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(6);
    exp_q.delete();
    check_flags("rstmid_after");
    add(8'h55, 1'b1);
    send_frame();
    check_flags("rstmid_flags");
    drain("rstmid");
  endtask

  task automatic test_random;
    int n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 11);
      for (int i = 0; i < n; i++) add($urandom_range(0, 255), $urandom_range(0, 1));
      send_frame();
      check_flags("rand");
      drain("rand");
      pulse_clear();
    end
  endtask

  task automatic test_back_to_back;
    add(8'hC3, 1'b0); add(8'h5A, 1'b1);
    send_frame();
    add(8'h01, 1'b0); add(8'hFF, 1'b1);
    send_frame();
    check_flags("b2b");
    drain("b2b");
  endtask

  initial begin
    test_reset();
    test_caset();
    test_overflow();
    test_frame_err();
    test_latency();
    test_pixel();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
